// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard/stall controller for the 5-stage core: load-use interlock, multicycle
// mul/div sequencing with timeout detection, and a free-running stall-cycle counter.
module hazard_stall_ctrl #(
   parameter int MD_TIMEOUT = 64,
   parameter int CNT_W      = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [31:0]      fd_insn,
   input  logic [31:0]      dx_insn,
   input  logic             md_ready,
   output logic             pc_enable,
   output logic             fd_enable,
   output logic             dx_enable,
   output logic             xm_enable,
   output logic             dx_bubble,
   output logic             xm_bubble,
   output logic             md_start,
   output logic             md_timeout,
   output logic [CNT_W-1:0] stall_count
);

   localparam int TW = $clog2(MD_TIMEOUT + 1);
   localparam logic [TW-1:0] TMO_MAX  = TW'(MD_TIMEOUT);
   localparam logic [TW-1:0] TMO_LAST = TW'(MD_TIMEOUT - 1);

   localparam logic [4:0] OP_ALU  = 5'b00000;
   localparam logic [4:0] OP_BNE  = 5'b00010;
   localparam logic [4:0] OP_JR   = 5'b00100;
   localparam logic [4:0] OP_ADDI = 5'b00101;
   localparam logic [4:0] OP_BLT  = 5'b00110;
   localparam logic [4:0] OP_SW   = 5'b00111;
   localparam logic [4:0] OP_LW   = 5'b01000;
   localparam logic [4:0] ALU_MUL = 5'b00110;
   localparam logic [4:0] ALU_DIV = 5'b00111;

   typedef enum logic {IDLE, BUSY} state_t;

   state_t           state_q, state_d;
   logic [TW-1:0]    tmo_cnt_q, tmo_cnt_d;
   logic             md_timeout_q, md_timeout_d;
   logic [CNT_W-1:0] stall_count_q, stall_count_d;

   logic [4:0] fd_op, fd_rd, fd_rs, fd_rt;
   logic [4:0] dx_op, dx_rd, dx_aluop;
   logic       dx_is_lw, dx_is_md;
   logic       fd_reads_rs, fd_reads_rt, fd_reads_rd;
   logic       load_use;

   // Instruction field decode and load-use detection
   always_comb begin
      fd_op    = fd_insn[31:27];
      fd_rd    = fd_insn[26:22];
      fd_rs    = fd_insn[21:17];
      fd_rt    = fd_insn[16:12];
      dx_op    = dx_insn[31:27];
      dx_rd    = dx_insn[26:22];
      dx_aluop = dx_insn[6:2];

      dx_is_lw = (dx_op == OP_LW) && (dx_rd != 5'd0);
      dx_is_md = (dx_op == OP_ALU) && ((dx_aluop == ALU_MUL) || (dx_aluop == ALU_DIV));

      fd_reads_rs = (fd_op == OP_ALU) || (fd_op == OP_ADDI) || (fd_op == OP_LW) ||
                    (fd_op == OP_SW)  || (fd_op == OP_BNE)  || (fd_op == OP_BLT);
      fd_reads_rt = (fd_op == OP_ALU);
      fd_reads_rd = (fd_op == OP_SW) || (fd_op == OP_BNE) || (fd_op == OP_BLT) ||
                    (fd_op == OP_JR);

      // dx_rd is nonzero whenever dx_is_lw holds, so r0 can never match here
      load_use = dx_is_lw && ((fd_reads_rs && (fd_rs == dx_rd)) ||
                              (fd_reads_rt && (fd_rt == dx_rd)) ||
                              (fd_reads_rd && (fd_rd == dx_rd)));
   end

   // Next state and control outputs
   always_comb begin
      state_d      = state_q;
      tmo_cnt_d    = tmo_cnt_q;
      md_timeout_d = md_timeout_q;
      pc_enable    = 1'b1;
      fd_enable    = 1'b1;
      dx_enable    = 1'b1;
      xm_enable    = 1'b1;
      dx_bubble    = 1'b0;
      xm_bubble    = 1'b0;
      md_start     = 1'b0;

      case (state_q)
         IDLE: begin
            tmo_cnt_d = '0;
            if (dx_is_md) begin
               // mul/div holds in DX while a nop drains into XM
               md_start  = 1'b1;
               pc_enable = 1'b0;
               fd_enable = 1'b0;
               dx_enable = 1'b0;
               xm_bubble = 1'b1;
               state_d   = BUSY;
            end else if (load_use) begin
               pc_enable = 1'b0;
               fd_enable = 1'b0;
               dx_bubble = 1'b1;
            end
         end
         BUSY: begin
            if (md_ready) begin
               tmo_cnt_d = '0;
               state_d   = IDLE;
            end else begin
               pc_enable = 1'b0;
               fd_enable = 1'b0;
               dx_enable = 1'b0;
               xm_bubble = 1'b1;
               if (tmo_cnt_q != TMO_MAX) tmo_cnt_d = tmo_cnt_q + 1'b1;
               if (tmo_cnt_q == TMO_LAST) md_timeout_d = 1'b1;
            end
         end
      endcase

      stall_count_d = pc_enable ? stall_count_q : stall_count_q + CNT_W'(1);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= IDLE;
         tmo_cnt_q     <= '0;
         md_timeout_q  <= 1'b0;
         stall_count_q <= '0;
      end else begin
         state_q       <= state_d;
         tmo_cnt_q     <= tmo_cnt_d;
         md_timeout_q  <= md_timeout_d;
         stall_count_q <= stall_count_d;
      end
   end

   assign md_timeout  = md_timeout_q;
   assign stall_count = stall_count_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl: directed scenarios plus random instruction
// streams compared cycle-by-cycle against a behavioural model of the stall rules.
module tb_hazard_stall_ctrl;
   localparam int TMO = 8;
   localparam int CW  = 8;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [31:0]   fd_insn = '0;
   logic [31:0]   dx_insn = '0;
   logic          md_ready = 1'b0;
   logic          pc_enable, fd_enable, dx_enable, xm_enable;
   logic          dx_bubble, xm_bubble, md_start, md_timeout;
   logic [CW-1:0] stall_count;

   int n_checks = 0;
   int n_pass   = 0;

   // behavioural model state
   bit          m_busy;
   bit          m_tmo;
   int          m_wait;
   int unsigned m_stall;

   // {pc, fd, dx, xm, dx_bubble, xm_bubble, md_start}
   localparam logic [6:0] GO     = 7'b1111_000;
   localparam logic [6:0] FREEZE = 7'b0001_010;
   localparam logic [6:0] START  = 7'b0001_011;
   localparam logic [6:0] LUSTAL = 7'b0011_100;

   hazard_stall_ctrl #(.MD_TIMEOUT(TMO), .CNT_W(CW)) dut (
      .clk(clk), .reset(reset), .fd_insn(fd_insn), .dx_insn(dx_insn), .md_ready(md_ready),
      .pc_enable(pc_enable), .fd_enable(fd_enable), .dx_enable(dx_enable),
      .xm_enable(xm_enable), .dx_bubble(dx_bubble), .xm_bubble(xm_bubble),
      .md_start(md_start), .md_timeout(md_timeout), .stall_count(stall_count)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] r_ins(input logic [4:0] op, rd, rs, rt, alu);
      return {op, rd, rs, rt, 5'd0, alu, 2'b00};
   endfunction

   function automatic logic [31:0] i_ins(input logic [4:0] op, rd, rs, input logic [16:0] imm);
      return {op, rd, rs, imm};
   endfunction

   function automatic bit is_md(input logic [31:0] i);
      return i[31:27] == 5'b00000 && (i[6:2] == 5'b00110 || i[6:2] == 5'b00111);
   endfunction

   // Registers the FD instruction sources, listed per opcode class
   function automatic bit hazard(input logic [31:0] fd, input logic [31:0] dx);
      int srcs[$];
      int op;
      if (dx[31:27] != 5'b01000 || dx[26:22] == 5'd0) return 0;
      op = int'(fd[31:27]);
      case (op)
         0:       begin srcs.push_back(int'(fd[21:17])); srcs.push_back(int'(fd[16:12])); end
         5, 8:    srcs.push_back(int'(fd[21:17]));
         7, 2, 6: begin srcs.push_back(int'(fd[21:17])); srcs.push_back(int'(fd[26:22])); end
         4:       srcs.push_back(int'(fd[26:22]));
         default: ;
      endcase
      foreach (srcs[k]) if (srcs[k] == int'(dx[26:22])) return 1;
      return 0;
   endfunction

   function automatic logic [6:0] model_ctrl(input logic [31:0] fd, dx, input logic rdy);
      if (m_busy) return rdy ? GO : FREEZE;
      if (is_md(dx)) return START;
      if (hazard(fd, dx)) return LUSTAL;
      return GO;
   endfunction

   function automatic logic [15:0] exp_vec();
      logic [31:0] s;
      s = m_stall;
      return {model_ctrl(fd_insn, dx_insn, md_ready), m_tmo, s[CW-1:0]};
   endfunction

   function automatic logic [15:0] obs_vec();
      return {pc_enable, fd_enable, dx_enable, xm_enable, dx_bubble, xm_bubble, md_start,
              md_timeout, stall_count};
   endfunction

   function automatic void model_clear();
      m_busy = 0; m_tmo = 0; m_wait = 0; m_stall = 0;
   endfunction

   function automatic void model_step();
      logic [6:0] c;
      c = model_ctrl(fd_insn, dx_insn, md_ready);
      if (!c[6]) m_stall = (m_stall + 1) % (1 << CW);
      if (!m_busy) begin
         if (is_md(dx_insn)) begin m_busy = 1; m_wait = 0; end
      end else if (md_ready) begin
         m_busy = 0;
      end else begin
         m_wait++;
         if (m_wait >= TMO) m_tmo = 1;
      end
   endfunction

   task automatic apply(input logic [31:0] fd, dx, input logic rdy);
      fd_insn = fd; dx_insn = dx; md_ready = rdy;
      @(negedge clk);
   endtask

   task automatic advance();
      @(posedge clk);
      if (!reset) model_step();
      #1;
   endtask

   task automatic do_reset();
      fd_insn = '0; dx_insn = '0; md_ready = 1'b0;
      reset = 1'b1;
      model_clear();
      @(posedge clk);
      #1 reset = 1'b0;
   endtask

   task automatic test_reset();
      #1;
      n_checks++;
      if (obs_vec() !== 16'hF000) $display("FAIL reset_state: got %h exp %h", obs_vec(), 16'hF000);
      else n_pass++;
      @(posedge clk);
      #1 reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         apply('0, '0, 1'b0);
         n_checks++;
         if (obs_vec() !== exp_vec()) $display("FAIL nop_stream: got %h exp %h", obs_vec(), exp_vec());
         else n_pass++;
         advance();
      end
   endtask

   task automatic test_load_use();
      logic [31:0] lw5, add, lw0, add0, sw5, nop;
      nop  = '0;
      lw5  = i_ins(5'b01000, 5'd5, 5'd2, 17'd0);
      add  = r_ins(5'b00000, 5'd7, 5'd5, 5'd3, 5'd0);
      lw0  = i_ins(5'b01000, 5'd0, 5'd2, 17'd4);
      add0 = r_ins(5'b00000, 5'd1, 5'd0, 5'd0, 5'd0);
      sw5  = i_ins(5'b00111, 5'd5, 5'd1, 17'd0);
      do_reset();
      apply(add, lw5, 1'b0);
      n_checks++;
      if (obs_vec() !== exp_vec()) $display("FAIL lu_stall: got %h exp %h", obs_vec(), exp_vec());
      else n_pass++;
      n_checks++;
      if ({pc_enable, fd_enable, dx_bubble} !== 3'b001)
         $display("FAIL lu_stall_bits: got %b exp 001", {pc_enable, fd_enable, dx_bubble});
      else n_pass++;
      advance();
      apply(add, nop, 1'b0);
      n_checks++;
      if (obs_vec() !== exp_vec()) $display("FAIL lu_flow: got %h exp %h", obs_vec(), exp_vec());
      else n_pass++;
      n_checks++;
      if (stall_count !== 8'd1) $display("FAIL lu_count: got %0d exp 1", stall_count);
      else n_pass++;
      advance();
      apply(add0, lw0, 1'b0);
      n_checks++;
      if (pc_enable !== 1'b1 || obs_vec() !== exp_vec())
         $display("FAIL lu_r0: got %h exp %h", obs_vec(), exp_vec());
      else n_pass++;
      advance();
      apply(sw5, lw5, 1'b0);
      n_checks++;
      if (pc_enable !== 1'b0 || obs_vec() !== exp_vec())
         $display("FAIL lu_sw_rd: got %h exp %h", obs_vec(), exp_vec());
      else n_pass++;
      advance();
   endtask

   task automatic test_muldiv();
      logic [31:0] mul;
      int starts;
      mul = r_ins(5'b00000, 5'd4, 5'd1, 5'd2, 5'b00110);
      starts = 0;
      do_reset();
      for (int i = 0; i < 7; i++) begin
         apply('0, mul, i == 6);
         if (md_start === 1'b1) starts++;
         n_checks++;
         if (obs_vec() !== exp_vec()) $display("FAIL md_seq%0d: got %h exp %h", i, obs_vec(), exp_vec());
         else n_pass++;
         advance();
      end
      apply('0, '0, 1'b0);
      n_checks++;
      if (stall_count !== 8'd6 || starts != 1)
         $display("FAIL md_count: got stall %0d starts %0d exp 6/1", stall_count, starts);
      else n_pass++;
      advance();
   endtask

   task automatic test_back_to_back();
      logic [31:0] mul, dv;
      mul = r_ins(5'b00000, 5'd4, 5'd1, 5'd2, 5'b00110);
      dv  = r_ins(5'b00000, 5'd6, 5'd4, 5'd3, 5'b00111);
      do_reset();
      for (int i = 0; i < 4; i++) begin
         apply(dv, mul, i == 3);
         n_checks++;
         if (obs_vec() !== exp_vec()) $display("FAIL b2b_first%0d: got %h exp %h", i, obs_vec(), exp_vec());
         else n_pass++;
         advance();
      end
      apply('0, dv, 1'b0);
      n_checks++;
      if (md_start !== 1'b1 || obs_vec() !== exp_vec())
         $display("FAIL b2b_second_start: got %h exp %h", obs_vec(), exp_vec());
      else n_pass++;
      advance();
      apply('0, dv, 1'b1);
      n_checks++;
      if (obs_vec() !== exp_vec()) $display("FAIL b2b_done: got %h exp %h", obs_vec(), exp_vec());
      else n_pass++;
      advance();
   endtask

   task automatic test_timeout();
      logic [31:0] mul;
      mul = r_ins(5'b00000, 5'd4, 5'd1, 5'd2, 5'b00110);
      do_reset();
      // 1 start cycle plus 8 BUSY cycles, then keep waiting long enough to wrap stall_count
      for (int i = 0; i < 300; i++) begin
         apply('0, mul, 1'b0);
         n_checks++;
         if (obs_vec() !== exp_vec()) $display("FAIL tmo_cyc%0d: got %h exp %h", i, obs_vec(), exp_vec());
         else n_pass++;
         if (i == 8 || i == 9) begin
            n_checks++;
            if (md_timeout !== (i == 9)) $display("FAIL tmo_edge%0d: got %b", i, md_timeout);
            else n_pass++;
         end
         advance();
      end
      apply('0, mul, 1'b0);
      #2 reset = 1'b1;
      model_clear();
      #1;
      n_checks++;
      if (md_timeout !== 1'b0 || stall_count !== 8'd0 || md_start !== 1'b1 || obs_vec() !== exp_vec())
         $display("FAIL async_reset: got %h exp %h", obs_vec(), exp_vec());
      else n_pass++;
      @(posedge clk);
      #1 reset = 1'b0;
      apply('0, '0, 1'b0);
      n_checks++;
      if (obs_vec() !== exp_vec()) $display("FAIL post_reset: got %h exp %h", obs_vec(), exp_vec());
      else n_pass++;
      advance();
   endtask

   function automatic logic [31:0] rand_insn();
      logic [4:0] a, b, c;
      a = 5'($urandom_range(0, 3));
      b = 5'($urandom_range(0, 3));
      c = 5'($urandom_range(0, 3));
      case ($urandom_range(0, 8))
         0, 1: return i_ins(5'b01000, a, b, 17'($urandom));
         2:    return r_ins(5'b00000, a, b, c, 5'($urandom_range(0, 5)));
         3:    return i_ins(5'b00101, a, b, 17'($urandom));
         4:    return i_ins(5'b00111, a, b, 17'($urandom));
         5:    return i_ins($urandom_range(0, 1) ? 5'b00010 : 5'b00110, a, b, 17'($urandom));
         6:    return i_ins(5'b00100, a, 5'd0, 17'd0);
         7:    return r_ins(5'b00000, a, b, c, $urandom_range(0, 1) ? 5'b00110 : 5'b00111);
         default: return i_ins(5'($urandom_range(9, 31)), a, b, 17'($urandom));
      endcase
   endfunction

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 500; i++) begin
         apply(rand_insn(), rand_insn(), $urandom_range(0, 3) == 0);
         n_checks++;
         if (obs_vec() !== exp_vec()) $display("FAIL rand%0d: got %h exp %h", i, obs_vec(), exp_vec());
         else n_pass++;
         advance();
      end
   endtask

   initial begin
      model_clear();
      test_reset();
      test_load_use();
      test_muldiv();
      test_back_to_back();
      test_timeout();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
